// File: rtl/knn_pkg.sv
// Shared types and default sizes for the KNN class voter.
// Optional build macro: KNN_VOTER_TIE_NEAREST_EN.
package knn_pkg;

  localparam int KNN_K           = 5;
  localparam int KNN_NUM_CLASSES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } voter_state_t;

endpackage

// File: rtl/knn_vote_counter.sv
// Per-class vote counters with clear and increment-by-index.
// KNN_VOTER_TIE_NEAREST_EN adds a first-vote rank store per class.
module knn_vote_counter
  import knn_pkg::*;
#(
  parameter int K           = KNN_K,
  parameter int NUM_CLASSES = KNN_NUM_CLASSES,
  parameter int LABEL_W     = 1,
  parameter int CNT_W       = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clr_i,
  input  logic                                 inc_i,
  input  logic [LABEL_W-1:0]                   idx_i,
`ifdef KNN_VOTER_TIE_NEAREST_EN
  input  logic [CNT_W-1:0]                     rank_i,
  output logic [NUM_CLASSES-1:0][CNT_W-1:0]    first_o,
`endif
  output logic [NUM_CLASSES-1:0][CNT_W-1:0]    cnt_o
);

  localparam logic [CNT_W-1:0] RANK_NONE = CNT_W'(K);

  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Next counts: clear wins; out-of-range labels match no class.
  always_comb begin
    cnt_d = cnt_q;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (clr_i) begin
        cnt_d[c] = '0;
      end else if (inc_i && idx_i == LABEL_W'(c)) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  // Count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

`ifdef KNN_VOTER_TIE_NEAREST_EN
  logic [NUM_CLASSES-1:0][CNT_W-1:0] first_q, first_d;

  // Capture the rank of each class's first vote only.
  always_comb begin
    first_d = first_q;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (clr_i) begin
        first_d[c] = RANK_NONE;
      end else if (inc_i && idx_i == LABEL_W'(c) &&
                   first_q[c] == RANK_NONE) begin
        first_d[c] = rank_i;
      end
    end
  end

  // First-rank registers, "none" encoded as K.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CLASSES; c++) first_q[c] <= RANK_NONE;
    end else begin
      first_q <= first_d;
    end
  end

  assign first_o = first_q;
`endif

endmodule

// File: rtl/knn_class_voter.sv
// K-neighbour majority voter: accumulate labels, scan counts, hold winner.
// Optional build macro: KNN_VOTER_TIE_NEAREST_EN (ties go to nearest vote).
module knn_class_voter
  import knn_pkg::*;
#(
  parameter  int K           = KNN_K,
  parameter  int NUM_CLASSES = KNN_NUM_CLASSES,
  localparam int LABEL_W     = $clog2(NUM_CLASSES),
  localparam int CNT_W       = $clog2(K + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_label_valid,
  input  logic [LABEL_W-1:0] i_label,
  output logic               o_label_ready,
  output logic               o_result_valid,
  output logic [LABEL_W-1:0] o_result_class,
  input  logic               i_result_ready,
  output logic               o_busy
);

  voter_state_t state_q, state_d;
  logic [CNT_W-1:0]   rank_q, rank_d;
  logic [LABEL_W-1:0] idx_q, idx_d;
  logic [LABEL_W-1:0] best_cls_q, best_cls_d;
  logic [CNT_W-1:0]   best_cnt_q, best_cnt_d;

  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_cnt;
  logic             accept;
  logic             hs;
  logic             better;

  assign accept  = (state_q == ACCUM) && i_label_valid;
  assign hs      = (state_q == DONE) && i_result_ready;
  assign cur_cnt = cnt[idx_q];

`ifdef KNN_VOTER_TIE_NEAREST_EN
  logic [NUM_CLASSES-1:0][CNT_W-1:0] first;
  logic [CNT_W-1:0] best_rank_q, best_rank_d;
  logic [CNT_W-1:0] cur_first;

  assign cur_first = first[idx_q];
  assign better = (cur_cnt > best_cnt_q) ||
                  (cur_cnt == best_cnt_q && cur_cnt != '0 &&
                   cur_first < best_rank_q);
`else
  assign better = cur_cnt > best_cnt_q;
`endif

  knn_vote_counter #(
    .K           (K),
    .NUM_CLASSES (NUM_CLASSES),
    .LABEL_W     (LABEL_W),
    .CNT_W       (CNT_W)
  ) u_cnt (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clr_i   (hs),
    .inc_i   (accept),
    .idx_i   (i_label),
`ifdef KNN_VOTER_TIE_NEAREST_EN
    .rank_i  (rank_q),
    .first_o (first),
`endif
    .cnt_o   (cnt)
  );

  // FSM next state, rank/scan progress and best-class tracking.
  always_comb begin
    state_d    = state_q;
    rank_d     = rank_q;
    idx_d      = idx_q;
    best_cls_d = best_cls_q;
    best_cnt_d = best_cnt_q;
`ifdef KNN_VOTER_TIE_NEAREST_EN
    best_rank_d = best_rank_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = ACCUM;
      end
      ACCUM: begin
        if (accept) begin
          rank_d = rank_q + CNT_W'(1);
          if (rank_q == CNT_W'(K - 1)) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (better) begin
          best_cls_d = idx_q;
          best_cnt_d = cur_cnt;
`ifdef KNN_VOTER_TIE_NEAREST_EN
          best_rank_d = cur_first;
`endif
        end
        if (idx_q == LABEL_W'(NUM_CLASSES - 1)) state_d = DONE;
        else idx_d = idx_q + LABEL_W'(1);
      end
      DONE: begin
        if (i_result_ready) begin
          state_d    = IDLE;
          rank_d     = '0;
          idx_d      = '0;
          best_cls_d = '0;
          best_cnt_d = '0;
`ifdef KNN_VOTER_TIE_NEAREST_EN
          best_rank_d = CNT_W'(K);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and tracking registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rank_q     <= '0;
      idx_q      <= '0;
      best_cls_q <= '0;
      best_cnt_q <= '0;
`ifdef KNN_VOTER_TIE_NEAREST_EN
      best_rank_q <= CNT_W'(K);
`endif
    end else begin
      state_q    <= state_d;
      rank_q     <= rank_d;
      idx_q      <= idx_d;
      best_cls_q <= best_cls_d;
      best_cnt_q <= best_cnt_d;
`ifdef KNN_VOTER_TIE_NEAREST_EN
      best_rank_q <= best_rank_d;
`endif
    end
  end

  assign o_label_ready  = (state_q == ACCUM);
  assign o_result_valid = (state_q == DONE);
  assign o_result_class = best_cls_q;
  assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_knn_class_voter.sv
// Scoreboard bench for knn_class_voter on three configurations:
// g0 K=5/C=2, g1 K=6/C=3, g2 K=5/C=3.
module tb_knn_class_voter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0]      start  = '0;
  logic [2:0]      lvalid = '0;
  logic [2:0]      rready = '1;
  logic [2:0][3:0] label  = '0;
  logic [2:0]      lready;
  logic [2:0]      rvalid;
  logic [2:0]      busy;
  logic [2:0][3:0] rcls;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KG = (g == 1) ? 6 : 5;
    localparam int CG = (g == 0) ? 2 : 3;
    localparam int LW = $clog2(CG);
    logic [LW-1:0] cls;
    knn_class_voter #(.K(KG), .NUM_CLASSES(CG)) u_dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_start        (start[g]),
      .i_label_valid  (lvalid[g]),
      .i_label        (label[g][LW-1:0]),
      .o_label_ready  (lready[g]),
      .o_result_valid (rvalid[g]),
      .o_result_class (cls),
      .i_result_ready (rready[g]),
      .o_busy         (busy[g])
    );
    assign rcls[g] = 4'(cls);
  end

  function automatic int k_of(input int g);
    return (g == 1) ? 6 : 5;
  endfunction

  function automatic int c_of(input int g);
    return (g == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int g, input int e);
    case (g)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Monitor: pop and compare on every result handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        int e;
        int sz;
        e = -1;
        case (g)
          0: sz = q0.size();
          1: sz = q1.size();
          default: sz = q2.size();
        endcase
        if (rvalid[g] && sz == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result_g%0d: got class %0d expected none",
                   g, rcls[g]);
        end else if (rvalid[g] && rready[g]) begin
          case (g)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("result_g%0d", g), int'(rcls[g]), e);
        end
      end
    end
  end

  int t0;

  // Start a vote and feed nb beats; stall inserts an idle cycle per beat.
  task automatic vote(input int g, input int lab[8], input int nb,
                      input bit stall, input int exp);
    int w;
    if (exp >= 0) push(g, exp);
    @(posedge clk); #1;
    start[g] = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start[g] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (stall) begin
        lvalid[g] = 1'b0;
        label[g]  = 4'd1;
        @(posedge clk); #1;
      end
      lvalid[g] = 1'b1;
      label[g]  = 4'(lab[i]);
      w = 0;
      @(negedge clk);
      while (!lready[g] && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!lready[g]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_timeout_g%0d: got ready 0 expected 1", g);
      end
      @(posedge clk); #1;
    end
    lvalid[g] = 1'b0;
    if (nb == k_of(g)) chk($sformatf("ready_drop_g%0d", g), int'(lready[g]), 0);
  endtask

  task automatic wait_valid(input int g, input bit check_lat);
    int w;
    w = 0;
    while (!rvalid[g] && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (!rvalid[g]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout_g%0d: got valid 0 expected 1", g);
    end else if (check_lat) begin
      chk($sformatf("latency_g%0d", g), cyc - t0, k_of(g) + c_of(g) + 1);
    end
  endtask

  task automatic wait_idle(input int g);
    int w;
    w = 0;
    while (busy[g] && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk($sformatf("idle_g%0d", g), int'(busy[g]), 0);
  endtask

  int tie_exp;

  initial begin
`ifdef KNN_VOTER_TIE_NEAREST_EN
    tie_exp = 2;
`else
    tie_exp = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_busy_g%0d", g), int'(busy[g]), 0);
      chk($sformatf("rst_lready_g%0d", g), int'(lready[g]), 0);
      chk($sformatf("rst_valid_g%0d", g), int'(rvalid[g]), 0);
      chk($sformatf("rst_class_g%0d", g), int'(rcls[g]), 0);
    end
    rst = 1'b0;

    vote(0, '{1, 0, 1, 1, 0, 0, 0, 0}, 5, 1'b0, 1);
    wait_valid(0, 1'b1);
    wait_idle(0);

    vote(0, '{1, 1, 0, 0, 0, 0, 0, 0}, 5, 1'b0, 0);
    wait_valid(0, 1'b1);
    wait_idle(0);

    vote(1, '{2, 1, 2, 1, 0, 0, 0, 0}, 6, 1'b0, tie_exp);
    wait_valid(1, 1'b1);
    wait_idle(1);

    vote(2, '{2, 2, 1, 0, 2, 0, 0, 0}, 5, 1'b1, 2);
    wait_valid(2, 1'b0);
    wait_idle(2);

    vote(2, '{3, 3, 3, 3, 3, 0, 0, 0}, 5, 1'b0, 0);
    wait_valid(2, 1'b1);
    wait_idle(2);

    vote(2, '{3, 3, 1, 3, 3, 0, 0, 0}, 5, 1'b0, 1);
    wait_valid(2, 1'b1);
    wait_idle(2);

    vote(0, '{1, 1, 1, 0, 0, 0, 0, 0}, 3, 1'b0, -1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_lready", int'(lready[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    vote(0, '{0, 0, 0, 1, 1, 0, 0, 0}, 5, 1'b0, 0);
    wait_valid(0, 1'b1);
    wait_idle(0);

    rready[2] = 1'b0;
    vote(2, '{0, 1, 1, 2, 1, 0, 0, 0}, 5, 1'b0, 1);
    wait_valid(2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", int'(rvalid[2]), 1);
      chk("hold_class", int'(rcls[2]), 1);
      start[2] = (i == 3);
      @(posedge clk); #1;
    end
    start[2]  = 1'b1;
    rready[2] = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    chk("release_busy", int'(busy[2]), 0);
    chk("release_valid", int'(rvalid[2]), 0);
    @(posedge clk); #1;
    chk("start_ignored_busy", int'(busy[2]), 0);

    vote(2, '{2, 2, 0, 3, 3, 0, 0, 0}, 5, 1'b0, 2);
    wait_valid(2, 1'b1);
    wait_idle(2);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_g0_empty", q0.size(), 0);
    chk("queue_g1_empty", q1.size(), 0);
    chk("queue_g2_empty", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
